des_round_engine: RTL and testbench
===================================

Name: des_round_engine

Overview:
Iterative DES encrypt/decrypt core: one Feistel round per clock over 16 rounds, with the key schedule computed on the fly.
- Sits directly upstream of, and wraps, the existing S1–S8 substitution boxes (each 6-bit in, 4-bit out). It builds each box's 6-bit input from expansion plus subkey XOR, and consumes the 4-bit outputs through the P permutation.
- Presents a valid/ready block interface to the surrounding design.

Parameters:
- NUM_ROUNDS, 16, rounds executed. Fixed for DES; other values are for debug only and do not produce DES results.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input block and key are valid.
- in_ready  out  1  engine can accept a block.
- in_decrypt  in  1  0 = encrypt, 1 = decrypt. Sampled at accept.
- in_block  in  64  plaintext or ciphertext. Bit 63 = DES bit 1.
- in_key  in  64  key including parity bits. Bit 63 = DES bit 1; parity bits are ignored.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_block  out  64  result. Bit 63 = DES bit 1.
- busy  out  1  high in ROUND or DONE.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; out_valid = 0; out_block = 0.
  - L, R, C, D, round counter and mode register = 0.
  - in_ready = 1 once rst_n is high.
  - Reset mid-operation aborts the block silently; no partial result is ever presented.
- State machine:
  - IDLE -> ROUND on in_valid && in_ready.
  - ROUND -> DONE when round counter = NUM_ROUNDS-1, at the end of that round.
  - DONE -> IDLE on out_ready.
- in_ready = (state == IDLE). in_valid seen outside IDLE is ignored, not queued.
- Accept cycle T:
  - {L0, R0} = IP(in_block).
  - {C0, D0} = PC1(in_key), 28 bits each.
  - Mode register captures in_decrypt; round counter = 0.
- Rounds 1..16 run in cycles T+1..T+16, one per cycle, counter 0..15.
- Key schedule, encrypt:
  - Before each round, rotate C and D left by 1 for rounds 1, 2, 9, 16 and by 2 otherwise.
  - Ki = PC2(C, D) using the rotated values.
- Key schedule, decrypt:
  - Round 1 uses PC2(C0, D0) with no rotation.
  - Rounds 2, 9, 16 rotate right by 1; all other rounds rotate right by 2.
  - Ki is taken after rotation, so subkeys come out K16 down to K1.
- Round function:
  - Li = R(i-1); Ri = L(i-1) XOR f(R(i-1), Ki).
  - f = P(S(E(R) XOR K)).
  - E: 32 -> 48 bits.
  - Box k (1..8) input = bits [47-6(k-1) : 42-6(k-1)] of E(R) XOR K.
  - Each box uses row = {in[5], in[0]} and column = in[4:1].
  - The eight 4-bit outputs are concatenated S1..S8, MSB first, then P is applied (32 -> 32 bits).
- Completion:
  - At the end of cycle T+16: out_block = FP({R16, L16}) (halves swapped); out_valid = 1.
  - out_valid and out_block first show as 1 and the result in cycle T+17.
  - out_block holds stable while out_valid && !out_ready.
  - Minimum accept-to-accept spacing is 18 cycles.
- Handshake edge cases:
  - When out_valid && out_ready: out_valid = 0 next cycle and the state returns to IDLE.
  - out_block keeps its last value until the next result.
  - out_ready while out_valid = 0 has no effect.
  - A back-to-back new in_valid waits in IDLE. It is not accepted in the same cycle as the out handshake.
- Widths and wrap-around:
  - Round counter is 4 bits and never wraps during operation.
  - C and D rotations are modulo 28.
  - After 16 encrypt rounds C/D equal C0/D0 (total shift 28); this is not relied on.
- Combinational only between registers. No latches; all tables are pure wiring.

Decomposition:
- Package des_pkg holds:
  - IP, FP, E, P, PC1 and PC2 index tables as localparam arrays.
  - The shift schedule, a 16-entry 1/2 table.
  - State enum {IDLE, ROUND, DONE} and width constants (BLOCK_W = 64, HALF_W = 32, SUBKEY_W = 48, CD_W = 28).
  - Permutation helper functions.
- Sub-module des_f_function (combinational):
  - Inputs: r[31:0], k[47:0]. Output: f[31:0].
  - Performs E, XOR, instantiates the existing S1..S8, then P.
- des_round_engine keeps the FSM, the L/R/C/D registers and the key schedule.

Test Plan:
1. Encrypt known-answer vector:
   - Stimulus: key 133457799BBCDFF1, block 0123456789ABCDEF, in_decrypt = 0.
   - Response: out_block = 85E813540F0AB405, out_valid rising exactly 17 cycles after accept.
2. Decrypt of test 1 result:
   - Stimulus: same key, block 85E813540F0AB405, in_decrypt = 1.
   - Response: out_block = 0123456789ABCDEF.
3. Second known-answer vector plus backpressure:
   - Stimulus: key 0E329232EA6D0D73, block 8787878787878787; out_ready held low for 5 cycles after out_valid.
   - Response: out_block = 0000000000000000 held stable; in_ready low throughout; handshake completes on the first cycle out_ready is high.
4. Parity-bit check and back-to-back operation:
   - Stimulus: key 0101010101010101, then key 0000000000000000, each with block 0000000000000000, issued back-to-back.
   - Response: both results = 8CA64DE9C1B123A7 (parity bits ignored); in_valid during the busy period is ignored; second accept occurs ≥18 cycles after the first.
5. Reset mid-operation:
   - Stimulus: assert rst_n = 0 asynchronously at round 7.
   - Response: out_valid = 0 and out_block = 0 immediately. After release, in_ready = 1, no stale out_valid, and the next vector from test 1 gives the correct result.
6. Subkey schedule check:
   - Stimulus: encrypt the test 1 vector while monitoring Ki each round.
   - Response: K1 = 1B02EFFC7072, K16 = CB3D8B0E17F5. In decrypt mode the order is reversed.

Source files
------------

// File: rtl/des_pkg.sv
// DES constant tables, permutation helpers and engine-wide types.
// Index tables use DES numbering: entry n names source bit n, where bit 1 is the MSB.
package des_pkg;

    localparam int BLOCK_W  = 64;
    localparam int HALF_W   = 32;
    localparam int SUBKEY_W = 48;
    localparam int CD_W     = 28;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_TBL [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // Parity bits 8, 16, ..., 64 never appear here, so they drop out of the key.
    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam int SHIFT_TBL [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Each box is stored row-major: entry = row * 16 + column.
    localparam int SBOX [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
    };

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_TBL[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_TBL[i]];
        return y;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[32-E_TBL[i]];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[31-i] = x[32-P_TBL[i]];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_TBL[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_TBL[i]];
        return y;
    endfunction

    function automatic logic [CD_W-1:0] rotl28(input logic [CD_W-1:0] x, input logic [1:0] n);
        logic [CD_W-1:0] y;
        case (n)
            2'd1:    y = {x[CD_W-2:0], x[CD_W-1]};
            2'd2:    y = {x[CD_W-3:0], x[CD_W-1:CD_W-2]};
            default: y = x;
        endcase
        return y;
    endfunction

    function automatic logic [CD_W-1:0] rotr28(input logic [CD_W-1:0] x, input logic [1:0] n);
        logic [CD_W-1:0] y;
        case (n)
            2'd1:    y = {x[0], x[CD_W-1:1]};
            2'd2:    y = {x[1:0], x[CD_W-1:2]};
            default: y = x;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/des_f_function.sv
// DES round function f(R, K) = P(S(E(R) xor K)); purely combinational.
module des_f_function
    import des_pkg::*;
(
    input  logic [HALF_W-1:0]   r,
    input  logic [SUBKEY_W-1:0] k,
    output logic [HALF_W-1:0]   f
);

    logic [SUBKEY_W-1:0] mixed;
    logic [HALF_W-1:0]   s_out;

    assign mixed = e_expand(r) ^ k;

    // S1 consumes the top six bits and produces the top nibble.
    for (genvar b = 0; b < 8; b++) begin : g_sbox
        des_sbox #(.BOX(b)) u_sbox (
            .box_i(mixed[SUBKEY_W-1-6*b -: 6]),
            .box_o(s_out[HALF_W-1-4*b -: 4])
        );
    end

    assign f = p_perm(s_out);

endmodule

// File: rtl/des_sbox.sv
// One DES substitution box, selected by BOX (0 = S1 .. 7 = S8); pure lookup wiring.
module des_sbox
    import des_pkg::*;
#(
    parameter int BOX = 0
) (
    input  logic [5:0] box_i,
    output logic [3:0] box_o
);

    logic [5:0] idx;

    // Outer bits pick the row, inner four bits pick the column.
    assign idx   = {box_i[5], box_i[0], box_i[4:1]};
    assign box_o = 4'(SBOX[BOX][idx]);

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES core: one Feistel round per clock, subkeys generated on the fly,
// valid/ready handshake on both block input and result.
module des_round_engine
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_decrypt,
    input  logic [BLOCK_W-1:0] in_block,
    input  logic [BLOCK_W-1:0] in_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_block,
    output logic               busy
);

    state_e              state_q, state_d;
    logic [HALF_W-1:0]   l_q, l_d, r_q, r_d;
    logic [CD_W-1:0]     c_q, c_d, d_q, d_d;
    logic [3:0]          round_q, round_d;
    logic                decrypt_q, decrypt_d;
    logic [BLOCK_W-1:0]  out_block_q, out_block_d;
    logic                out_valid_q, out_valid_d;

    logic [1:0]          shift_amt;
    logic [CD_W-1:0]     c_rot, d_rot;
    logic [SUBKEY_W-1:0] subkey;
    logic [HALF_W-1:0]   f_out, r_next;
    logic                last_round;

    // Decrypt walks the schedule backwards: the first subkey is PC2(C0, D0) unrotated,
    // later rounds undo the encrypt shift of the same table slot.
    always_comb begin
        shift_amt = 2'(SHIFT_TBL[round_q]);
        if (decrypt_q) begin
            if (round_q == 4'd0) shift_amt = 2'd0;
            c_rot = rotr28(c_q, shift_amt);
            d_rot = rotr28(d_q, shift_amt);
        end else begin
            c_rot = rotl28(c_q, shift_amt);
            d_rot = rotl28(d_q, shift_amt);
        end
    end

    assign subkey     = pc2_perm({c_rot, d_rot});
    assign r_next     = l_q ^ f_out;
    assign last_round = (round_q == 4'(NUM_ROUNDS - 1));

    des_f_function u_f (
        .r(r_q),
        .k(subkey),
        .f(f_out)
    );

    always_comb begin
        // NOTE: every target gets its hold value first so no path can infer a latch.
        state_d     = state_q;
        l_d         = l_q;
        r_d         = r_q;
        c_d         = c_q;
        d_d         = d_q;
        round_d     = round_q;
        decrypt_d   = decrypt_q;
        out_block_d = out_block_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d    = ROUND;
                    {l_d, r_d} = ip_perm(in_block);
                    {c_d, d_d} = pc1_perm(in_key);
                    round_d    = 4'd0;
                    decrypt_d  = in_decrypt;
                end
            end
            ROUND: begin
                l_d = r_q;
                r_d = r_next;
                c_d = c_rot;
                d_d = d_rot;
                if (last_round) begin
                    state_d     = DONE;
                    // Final output swaps the halves before the inverse permutation.
                    out_block_d = fp_perm({r_next, r_q});
                    out_valid_d = 1'b1;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            round_q     <= '0;
            decrypt_q   <= 1'b0;
            out_block_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            l_q         <= l_d;
            r_q         <= r_d;
            c_q         <= c_d;
            d_q         <= d_d;
            round_q     <= round_d;
            decrypt_q   <= decrypt_d;
            out_block_q <= out_block_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_block = out_block_q;

endmodule

// File: tb/tb_des_round_engine.sv
// Self-checking bench for des_round_engine: known-answer vectors, backpressure,
// back-to-back issue, mid-operation reset and subkey order.
module tb_des_round_engine;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b1;
    logic        in_valid   = 1'b0;
    logic        in_decrypt = 1'b0;
    logic        out_ready  = 1'b0;
    logic [63:0] in_block   = '0;
    logic [63:0] in_key     = '0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [63:0] out_block;

    des_round_engine #(.NUM_ROUNDS(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_decrypt(in_decrypt),
        .in_block  (in_block),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] key;
        logic [63:0] block;
        logic        dec;
        logic [63:0] expect_blk;
        int          hold;
    } vec_t;

    localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
    localparam logic [47:0] K1   = 48'h1B02EFFC7072;
    localparam logic [47:0] K16  = 48'hCB3D8B0E17F5;

    int          n_checks   = 0;
    int          n_pass     = 0;
    int          accept_cyc = 0;
    logic [63:0] sb [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    // Present a block, wait for acceptance, and record the expected result.
    task automatic send(input logic [63:0] key, input logic [63:0] blk, input logic dec,
                        input logic [63:0] exp);
        int waited = 0;
        @(negedge clk);
        in_valid   = 1'b1;
        in_key     = key;
        in_block   = blk;
        in_decrypt = dec;
        while (!in_ready && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        check("accept_seen", 64'(in_ready), 64'd1);
        accept_cyc = cyc;
        sb.push_back(exp);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Wait for the result, compare against the scoreboard, apply backpressure, then hand off.
    task automatic collect(input int hold, input bit check_lat);
        int          waited = 0;
        logic [63:0] exp;
        out_ready = 1'b0;
        while (!out_valid && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("out_valid_seen", 64'(out_valid), 64'd1);
        if (check_lat) check("latency", 64'(cyc - accept_cyc), 64'd17);
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        check("result", out_block, exp);
        for (int i = 0; i < hold; i++) begin
            check("hold_block", out_block, exp);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_busy", 64'(busy), 64'd1);
            @(negedge clk);
        end
        check("valid_before_ready", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("handshake_valid_low", 64'(out_valid), 64'd0);
        check("handshake_in_ready", 64'(in_ready), 64'd1);
        check("block_kept", out_block, exp);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs [3];
        int   first_acc;

        vecs[0] = '{key: KEY1, block: PT1, dec: 1'b0, expect_blk: CT1, hold: 0};
        vecs[1] = '{key: KEY1, block: CT1, dec: 1'b1, expect_blk: PT1, hold: 0};
        vecs[2] = '{key: 64'h0E329232EA6D0D73, block: 64'h8787878787878787, dec: 1'b0,
                    expect_blk: 64'h0000000000000000, hold: 5};

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_block", out_block, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", 64'(in_ready), 64'd1);
        check("post_reset_busy", 64'(busy), 64'd0);

        // Known-answer vectors, decrypt round trip, backpressure.
        for (int i = 0; i < 3; i++) begin
            send(vecs[i].key, vecs[i].block, vecs[i].dec, vecs[i].expect_blk);
            collect(vecs[i].hold, 1'b1);
        end

        // Parity bits ignored; second request held high through the busy period.
        send(64'h0101010101010101, 64'd0, 1'b0, 64'h8CA64DE9C1B123A7);
        first_acc  = accept_cyc;
        in_valid   = 1'b1;
        in_key     = 64'd0;
        in_block   = 64'd0;
        in_decrypt = 1'b0;
        collect(0, 1'b1);
        check("b2b_in_ready_idle", 64'(in_ready && in_valid), 64'd1);
        accept_cyc = cyc;
        sb.push_back(64'h8CA64DE9C1B123A7);
        check("b2b_spacing_ge18", 64'(accept_cyc - first_acc >= 18), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        collect(0, 1'b1);

        // Asynchronous reset in the middle of round 7.
        send(KEY1, PT1, 1'b0, CT1);
        repeat (7) @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out_block", out_block, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_stale_valid", 64'(out_valid), 64'd0);
            check("abort_in_ready", 64'(in_ready), 64'd1);
        end
        send(KEY1, PT1, 1'b0, CT1);
        collect(0, 1'b1);

        // Subkey order: K1..K16 for encrypt, K16..K1 for decrypt.
        send(KEY1, PT1, 1'b0, CT1);
        @(negedge clk);
        check("enc_round1_subkey", 64'(dut.subkey), 64'(K1));
        repeat (15) @(negedge clk);
        check("enc_round16_subkey", 64'(dut.subkey), 64'(K16));
        collect(0, 1'b0);

        send(KEY1, CT1, 1'b1, PT1);
        @(negedge clk);
        check("dec_round1_subkey", 64'(dut.subkey), 64'(K16));
        repeat (15) @(negedge clk);
        check("dec_round16_subkey", 64'(dut.subkey), 64'(K1));
        collect(0, 1'b0);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
